// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and mux for the serial slave bus.
// Each grant tenure can be revoked by a hold timeout. Every change of owner passes through a one-cycle turnaround.
module bus_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m1_validIn,
  input  logic m1_wren,
  input  logic m1_Address,
  input  logic m1_DataIn,
  input  logic m2_req,
  input  logic m2_validIn,
  input  logic m2_wren,
  input  logic m2_Address,
  input  logic m2_DataIn,
  input  logic s_ready,
  input  logic s_validOut,
  input  logic s_DataOut,
  output logic validIn,
  output logic wren,
  output logic Address,
  output logic DataIn,
  output logic m1_grant,
  output logic m2_grant,
  output logic m1_ready,
  output logic m1_validOut,
  output logic m1_DataOut,
  output logic m2_ready,
  output logic m2_validOut,
  output logic m2_DataOut,
  output logic timeout
);

  // state | meaning
  // IDLE  | no owner, arbitrating among eligible masters
  // GNT1  | master 1 owns the bus
  // GNT2  | master 2 owns the bus
  // TURN  | one dead cycle between owners

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;

  state_t        state;
  logic          last_owner;   // 0 = M1, 1 = M2
  logic [CW-1:0] counter;
  logic          block1;
  logic          block2;
  logic          elig1;
  logic          elig2;
  logic          tmo_hit;

  assign elig1   = m1_req && !block1;
  assign elig2   = m2_req && !block2;
  assign tmo_hit = (TIMEOUT != 0) && (counter == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      counter    <= '0;
      block1     <= 1'b0;
      block2     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!m1_req) block1 <= 1'b0;
      if (!m2_req) block2 <= 1'b0;
      if (counter != CNT_SAT) counter <= counter + 1'b1;
      case (state)
        IDLE: begin
          if (elig1 && (!elig2 || last_owner)) begin
            state      <= GNT1;
            last_owner <= 1'b0;
            counter    <= '0;
          end else if (elig2) begin
            state      <= GNT2;
            last_owner <= 1'b1;
            counter    <= '0;
          end
        end
        // A release on the same edge as the limit takes priority over the timeout.
        GNT1: begin
          if (!m1_req) begin
            state <= TURN;
          end else if (tmo_hit) begin
            state   <= TURN;
            timeout <= 1'b1;
            block1  <= 1'b1;
          end
        end
        GNT2: begin
          if (!m2_req) begin
            state <= TURN;
          end else if (tmo_hit) begin
            state   <= TURN;
            timeout <= 1'b1;
            block2  <= 1'b1;
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m1_grant = (state == GNT1);
  assign m2_grant = (state == GNT2);

  always_comb begin
    validIn     = 1'b0;
    wren        = 1'b0;
    Address     = 1'b0;
    DataIn      = 1'b0;
    m1_ready    = 1'b0;
    m1_validOut = 1'b0;
    m1_DataOut  = 1'b0;
    m2_ready    = 1'b0;
    m2_validOut = 1'b0;
    m2_DataOut  = 1'b0;
    case (state)
      GNT1: begin
        validIn     = m1_validIn;
        wren        = m1_wren;
        Address     = m1_Address;
        DataIn      = m1_DataIn;
        m1_ready    = s_ready;
        m1_validOut = s_validOut;
        m1_DataOut  = s_DataOut;
      end
      GNT2: begin
        validIn     = m2_validIn;
        wren        = m2_wren;
        Address     = m2_Address;
        DataIn      = m2_DataIn;
        m2_ready    = s_ready;
        m2_validOut = s_validOut;
        m2_DataOut  = s_DataOut;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic.
// A tenure-level reference model is compared against the DUT on every falling edge.
module tb_bus_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m1_req = 0, m1_validIn = 0, m1_wren = 0, m1_Address = 0, m1_DataIn = 0;
  logic m2_req = 0, m2_validIn = 0, m2_wren = 0, m2_Address = 0, m2_DataIn = 0;
  logic s_ready = 0, s_validOut = 0, s_DataOut = 0;
  logic validIn, wren, Address, DataIn, m1_grant, m2_grant;
  logic m1_ready, m1_validOut, m1_DataOut, m2_ready, m2_validOut, m2_DataOut, timeout;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m1_req(m1_req), .m1_validIn(m1_validIn), .m1_wren(m1_wren),
    .m1_Address(m1_Address), .m1_DataIn(m1_DataIn),
    .m2_req(m2_req), .m2_validIn(m2_validIn), .m2_wren(m2_wren),
    .m2_Address(m2_Address), .m2_DataIn(m2_DataIn),
    .s_ready(s_ready), .s_validOut(s_validOut), .s_DataOut(s_DataOut),
    .validIn(validIn), .wren(wren), .Address(Address), .DataIn(DataIn),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .m1_ready(m1_ready), .m1_validOut(m1_validOut), .m1_DataOut(m1_DataOut),
    .m2_ready(m2_ready), .m2_validOut(m2_validOut), .m2_DataOut(m2_DataOut),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many cycles it has held it, and
  // whether a dead cycle is pending; blk[] marks a master cut off by timeout.
  int mown = 0, mheld = 0, mlast = 2, mpick = 0;
  bit mgap = 0, mpulse = 0;
  bit mblk[3] = '{0, 0, 0};
  bit rq[3] = '{0, 0, 0};
  bit el[3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mown = 0; mheld = 0; mlast = 2; mgap = 0; mpulse = 0;
      mblk = '{0, 0, 0};
    end else begin
      rq[1] = m1_req; rq[2] = m2_req;
      mpulse = 0;
      if (mown != 0) begin
        mheld++;
        if (!rq[mown]) begin
          mown = 0; mgap = 1;
        end else if (mheld == TMO) begin
          mblk[mown] = 1; mown = 0; mgap = 1; mpulse = 1;
        end
      end else if (mgap) begin
        mgap = 0;
      end else begin
        el[1] = rq[1] && !mblk[1];
        el[2] = rq[2] && !mblk[2];
        mpick = 0;
        if (el[1] && el[2]) mpick = 3 - mlast;
        else if (el[1]) mpick = 1;
        else if (el[2]) mpick = 2;
        if (mpick != 0) begin
          mown = mpick; mheld = 0; mlast = mpick;
        end
      end
      for (int x = 1; x <= 2; x++) if (!rq[x]) mblk[x] = 0;
    end
  end

  logic [3:0] exp_fwd;
  logic [2:0] exp_r1, exp_r2;
  always @(negedge clk) begin
    exp_fwd = (mown == 1) ? {m1_validIn, m1_wren, m1_Address, m1_DataIn} :
              (mown == 2) ? {m2_validIn, m2_wren, m2_Address, m2_DataIn} : 4'b0;
    exp_r1 = (mown == 1) ? {s_ready, s_validOut, s_DataOut} : 3'b0;
    exp_r2 = (mown == 2) ? {s_ready, s_validOut, s_DataOut} : 3'b0;
    chk("fwd", {12'b0, validIn, wren, Address, DataIn}, {12'b0, exp_fwd});
    chk("grant", {14'b0, m1_grant, m2_grant}, {14'b0, mown == 1, mown == 2});
    chk("ret1", {13'b0, m1_ready, m1_validOut, m1_DataOut}, {13'b0, exp_r1});
    chk("ret2", {13'b0, m2_ready, m2_validOut, m2_DataOut}, {13'b0, exp_r2});
    chk("timeout", {15'b0, timeout}, {15'b0, mpulse});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [11:0] addr;
  logic [7:0]  data;
  int gcnt, tcnt;
  bit found;

  initial begin
    #2;
    chk("rst_grants", {14'b0, m1_grant, m2_grant}, 16'd0);
    chk("rst_fwd", {12'b0, validIn, wren, Address, DataIn}, 16'd0);
    chk("rst_tmo", {15'b0, timeout}, 16'd0);
    tick();
    rst = 1'b0;
    tick();

    // Write via M1 alone
    addr = 12'h12D; data = 8'hA5;
    m1_req = 1; m1_validIn = 1; m1_wren = 1;
    m1_Address = addr[11]; m1_DataIn = data[7];
    tick();
    chk("t1_grant", {15'b0, m1_grant}, 16'd1);
    for (int i = 1; i <= 6; i++) begin
      m1_Address = addr[11-i]; m1_DataIn = data[7-i];
      tick();
      chk("t1_m2ret", {13'b0, m2_ready, m2_validOut, m2_DataOut}, 16'd0);
    end
    m1_req = 0; m1_validIn = 0; m1_wren = 0;
    tick();
    chk("t1_drop", {14'b0, m1_grant, timeout}, 16'd0);
    tick();
    chk("t1_idle", {15'b0, m1_grant}, 16'd0);

    // Simultaneous requests after reset
    reset_dut();
    m1_req = 1; m2_req = 1;
    tick();
    chk("t2_m1_first", {14'b0, m1_grant, m2_grant}, 16'd2);
    tick(); tick();
    m1_req = 0;
    tick(); chk("t2_e1", {15'b0, m2_grant}, 16'd0);
    tick(); chk("t2_e2", {15'b0, m2_grant}, 16'd0);
    tick(); chk("t2_e3", {15'b0, m2_grant}, 16'd1);
    m2_req = 0;
    tick(); tick();
    m1_req = 1; m2_req = 1;
    tick();
    chk("t2_alt", {14'b0, m1_grant, m2_grant}, 16'd2);
    m1_req = 0; m2_req = 0;
    tick(); tick();

    // M2 holds, M1 waits without preemption
    m2_req = 1;
    tick();
    m1_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_nopre", {14'b0, m1_grant, m2_grant}, 16'd1);
    end
    m2_req = 0;
    tick(); chk("t3_turn", {15'b0, m1_grant}, 16'd0);
    tick(); chk("t3_idle", {15'b0, m1_grant}, 16'd0);
    tick(); chk("t3_m1", {15'b0, m1_grant}, 16'd1);
    m1_req = 0;
    tick(); tick();

    // Timeout with M1 holding request
    m1_req = 1; gcnt = 0; tcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      gcnt += int'(m1_grant);
      tcnt += int'(timeout);
    end
    chk("t4_tenure", 16'(gcnt), 16'd8);
    chk("t4_pulses", 16'(tcnt), 16'd1);
    m1_req = 0;
    tick();
    m1_req = 1;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (m1_grant) found = 1;
    end
    chk("t4_regrant", {15'b0, found}, 16'd1);
    m1_req = 0;
    tick(); tick();

    // Read via M2
    m2_req = 1; m2_validIn = 1; m2_wren = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      {s_ready, s_validOut, s_DataOut} = 3'($urandom);
      m2_Address = 1'($urandom); m2_DataIn = 1'($urandom);
      #1;
      chk("t5_m2ret", {13'b0, m2_ready, m2_validOut, m2_DataOut},
          {13'b0, s_ready, s_validOut, s_DataOut});
      chk("t5_m1ret", {13'b0, m1_ready, m1_validOut, m1_DataOut}, 16'd0);
      tick();
    end
    m2_req = 0; m2_validIn = 0;
    tick(); tick();

    // Asynchronous reset mid-tenure
    m1_req = 1; m1_validIn = 1; s_ready = 1;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("t6_grants", {14'b0, m1_grant, m2_grant}, 16'd0);
    chk("t6_bus", {9'b0, validIn, wren, Address, DataIn, m1_ready, m1_validOut, m1_DataOut}, 16'd0);
    tick();
    rst = 1'b0;
    m1_req = 0; m1_validIn = 0;
    tick();
    m1_req = 1; m2_req = 1;
    tick();
    chk("t6_m1_first", {14'b0, m1_grant, m2_grant}, 16'd2);
    m1_req = 0; m2_req = 0;
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m1_req) begin if ($urandom_range(5) == 0) m1_req = 0; end
      else if ($urandom_range(3) == 0) m1_req = 1;
      if (m2_req) begin if ($urandom_range(5) == 0) m2_req = 0; end
      else if ($urandom_range(3) == 0) m2_req = 1;
      {m1_validIn, m1_wren, m1_Address, m1_DataIn} = 4'($urandom);
      {m2_validIn, m2_wren, m2_Address, m2_DataIn} = 4'($urandom);
      {s_ready, s_validOut, s_DataOut} = 3'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and multiplexer for the serial slave bus.
- The bus carries per-bit lines validIn, wren, Address and DataIn from master to slave, and ready, validOut and DataOut from slave to master.
- Grants the bus round-robin, routes the granted master's serial lines to the slave side, and gates the slave's return lines back to that master only.
- Enforces a hold timeout and a one-cycle turnaround between owners.

Parameters:
TIMEOUT, 64, maximum consecutive granted cycles per tenure; 0 disables timeout
CW, $clog2(TIMEOUT+1), tenure counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
m1_req  input  1  master 1 bus request, held for the whole transaction
m1_validIn / m1_wren / m1_Address / m1_DataIn  input  1 each  master 1 serial lines
m2_req  input  1  master 2 bus request
m2_validIn / m2_wren / m2_Address / m2_DataIn  input  1 each  master 2 serial lines
s_ready / s_validOut / s_DataOut  input  1 each  slave return lines
validIn / wren / Address / DataIn  output  1 each  muxed lines to slave
m1_grant / m2_grant  output  1 each  bus granted to master
m1_ready / m1_validOut / m1_DataOut  output  1 each  gated return to master 1
m2_ready / m2_validOut / m2_DataOut  output  1 each  gated return to master 2
timeout  output  1  one-cycle pulse when a tenure is revoked

Behaviour:
- States: IDLE, GNT1, GNT2, TURN. State, last_owner, counter, timeout, block1 and block2 are registers.
- Reset (async, immediate): state=IDLE, last_owner=M2 (so M1 wins the first tie), counter=0, block1=block2=0. All outputs 0, including grants, muxed lines and timeout.
- Eligibility: master x is eligible when mx_req=1 and blockx=0.
- blockx clears on any edge where mx_req=0.
- IDLE arbitration:
  - Both masters eligible: grant the one that is not last_owner.
  - One master eligible: grant it.
  - Neither eligible: stay in IDLE.
  - On entering GNTx: last_owner<=x, counter<=0.
- Grant latency: req sampled high at edge k in IDLE, so mx_grant=1 during cycle k..k+1.
- Grants are decoded from the state only: exactly one grant high in GNTx, none in IDLE/TURN.
- GNTx routing (combinational):
  - validIn/wren/Address/DataIn = master x's lines.
  - mx_ready/validOut/DataOut = s_* lines.
  - The other master's return outputs = 0.
- In IDLE/TURN, all muxed and returned lines = 0.
- GNTx counter increments each cycle, saturating at TIMEOUT.
- GNTx exits:
  - mx_req=0 sampled: go to TURN, no timeout.
  - TIMEOUT!=0, counter==TIMEOUT-1 and mx_req=1: go to TURN, pulse timeout=1 for exactly the TURN cycle, set blockx=1.
  - If both exit conditions occur on the same edge, the release wins and no timeout is raised.
- TURN: always exactly one cycle, then IDLE.
  - Earliest re-grant = 3 edges after the owner drops req.
  - Gap of two no-grant cycles (TURN, IDLE).
- The other master's request is never served mid-tenure; no preemption.
- Reset mid-tenure: grant and all bus outputs drop asynchronously in the same cycle. The slave must be reset with the bus.
- Maximum tenure = TIMEOUT cycles of grant high.
- Fairness: with both masters requesting continuously, grants alternate M1, M2, M1, …

Test Plan:
- Reset, then m1_req=1 alone with a write (addr 0x12D, data 0xA5):
  - m1_grant rises 1 cycle after req.
  - Slave-side validIn/Address/DataIn match m1 bit-for-bit.
  - m2 return outputs stay 0.
  - After m1_req drops: grant falls the next edge, TURN lasts 1 cycle, timeout=0.
- m1_req and m2_req rise on the same edge after reset:
  - M1 granted first.
  - M2 is granted 3 edges after m1_req falls.
  - A following simultaneous request grants M1 again (alternation).
- M2 holds the bus with M1 requesting mid-tenure:
  - No preemption; m1_grant stays 0 until M2 releases, then TURN, then M1 granted.
- TIMEOUT=8, m1_req held high:
  - m1_grant is high exactly 8 cycles, then a timeout pulse of 1 cycle.
  - M1 is not re-granted while req stays high.
  - Dropping req for 1 cycle and raising it re-grants M1.
- Read via M2 (wren=0):
  - s_ready/s_validOut/s_DataOut toggles appear only on m2_* return outputs.
  - m1_* return outputs stay 0.
- rst asserted mid-tenure between clock edges:
  - All grants and bus lines go to 0 before the next edge.
  - After release, a simultaneous request grants M1 first.
